// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding and opcode constants
// used by alu, alu_seq and the SRP16 decoder.
package alu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EXEC = 3'd2,
        ST_READ = 3'd3,
        ST_RESP = 3'd4
    } seq_state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b00101;
    localparam logic [4:0] OP_SHL1 = 5'b01000;
    localparam logic [4:0] OP_SHR1 = 5'b01001;

endpackage

// File: rtl/alu_seq_cnt.sv
// Loadable repeat down-counter with zero detect; saturates at zero so a
// stray decrement can never wrap to the maximum count.
module alu_seq_cnt #(
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [CNTW-1:0] load_val,
    input  logic            dec,
    output logic [CNTW-1:0] value,
    output logic            zero
);

    logic [CNTW-1:0] rep_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_reg <= '0;
        end else if (load) begin
            rep_reg <= load_val;
        end else if (dec && (rep_reg != '0)) begin
            rep_reg <= rep_reg - 1'b1;
        end
    end

    assign value = rep_reg;
    assign zero  = (rep_reg == '0);

endmodule

// File: rtl/alu_seq.sv
// Command sequencer for the accumulator ALU: load, execute opcode N times,
// read back, then hand the result over a valid/ready response port.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W    = 16,
    parameter int OPW  = 5,
    parameter int CNTW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OPW-1:0]  req_opcode,
    input  logic [W-1:0]    req_a,
    input  logic [W-1:0]    req_b,
    input  logic [CNTW-1:0] req_count,
    input  logic            req_keep,
    input  logic            req_upper,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_flag,
    output logic [OPW-1:0]  alu_opcode,
    output logic [W-1:0]    alu_operand,
    output logic            alu_read,
    output logic            alu_write,
    output logic            alu_writeu,
    input  logic [W-1:0]    alu_accout,
    input  logic            alu_flag
);

    seq_state_t      state_reg, state_next;
    logic [OPW-1:0]  opcode_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            upper_reg;
    logic [W-1:0]    rsp_data_reg;
    logic            rsp_flag_reg;

    logic            cnt_load;
    logic            cnt_dec;
    logic [CNTW-1:0] rep_value;
    logic            rep_zero;

    alu_seq_cnt #(.CNTW(CNTW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (req_count),
        .dec      (cnt_dec),
        .value    (rep_value),
        .zero     (rep_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            opcode_reg   <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            upper_reg    <= 1'b0;
            rsp_data_reg <= '0;
            rsp_flag_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && req_valid) begin
                opcode_reg <= req_opcode;
                a_reg      <= req_a;
                b_reg      <= req_b;
                upper_reg  <= req_upper;
            end
            if (state_reg == ST_READ) begin
                rsp_data_reg <= alu_accout;
                rsp_flag_reg <= alu_flag;
            end
        end
    end

    // ALU pins decode from the state register only, so nothing on the
    // request or response ports can reach them combinationally.
    always_comb begin
        state_next  = state_reg;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_opcode  = '0;
        alu_operand = '0;
        alu_read    = 1'b0;
        alu_write   = 1'b0;
        alu_writeu  = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cnt_load   = 1'b1;
                    state_next = req_keep ? ST_EXEC : ST_LOAD;
                end
            end
            ST_LOAD: begin
                alu_opcode  = OPW'(OP_NOP);
                alu_operand = a_reg;
                alu_write   = ~upper_reg;
                alu_writeu  = upper_reg;
                state_next  = ST_EXEC;
            end
            ST_EXEC: begin
                alu_opcode  = opcode_reg;
                alu_operand = b_reg;
                if (rep_zero) begin
                    state_next = ST_READ;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_READ: begin
                alu_read   = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_flag = rsp_flag_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU on the control pins, scoreboard of
// expected results, per-job latency and strobe accounting.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;
    localparam int OPW = 5;
    localparam int CNTW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [OPW-1:0]  req_opcode = '0;
    logic [W-1:0]    req_a = '0;
    logic [W-1:0]    req_b = '0;
    logic [CNTW-1:0] req_count = '0;
    logic            req_keep = 1'b0;
    logic            req_upper = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [W-1:0]    rsp_data;
    logic            rsp_flag;
    logic [OPW-1:0]  alu_opcode;
    logic [W-1:0]    alu_operand;
    logic            alu_read;
    logic            alu_write;
    logic            alu_writeu;
    logic [W-1:0]    alu_accout;
    logic            alu_flag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] data;
        logic         flag;
        int           lat;
        int           nex;
        int           nwr;
        int           nwru;
    } exp_t;
    exp_t sbq[$];

    logic [W-1:0] ref_acc = '0;
    logic         ref_flag = 1'b0;

    alu_seq #(.W(W), .OPW(OPW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
        .req_count(req_count), .req_keep(req_keep), .req_upper(req_upper),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flag(rsp_flag),
        .alu_opcode(alu_opcode), .alu_operand(alu_operand),
        .alu_read(alu_read), .alu_write(alu_write), .alu_writeu(alu_writeu),
        .alu_accout(alu_accout), .alu_flag(alu_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] alu_op(input logic [OPW-1:0] op, input logic [W-1:0] acc,
                                          input logic [W-1:0] b, input logic c);
        logic [W:0] r;
        case (op)
            OP_ADD:  r = {1'b0, acc} + {1'b0, b};
            OP_SUB:  r = {1'b0, acc} - {1'b0, b};
            OP_SHL1: r = {acc[W-1], acc[W-2:0], 1'b0};
            OP_SHR1: r = {acc[0], 1'b0, acc[W-1:1]};
            default: r = {c, acc};
        endcase
        return r;
    endfunction

    // Behavioural accumulator ALU driven by the sequencer's pins.
    logic [W-1:0] m_acc = '0;
    logic         m_c = 1'b0;
    always @(posedge clk) begin
        if (alu_write) m_acc <= alu_operand;
        else if (alu_writeu) m_acc[W-1:8] <= alu_operand[W-1:8];
        else if (!alu_read) {m_c, m_acc} <= alu_op(alu_opcode, m_acc, alu_operand, m_c);
    end
    assign alu_accout = m_acc;
    assign alu_flag   = m_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [OPW-1:0] op, input logic [W-1:0] a, b,
                             input logic [CNTW-1:0] cnt, input logic keep, upper);
        @(negedge clk);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
        req_count = cnt; req_keep = keep; req_upper = upper;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_job(input logic [OPW-1:0] op, input logic [W-1:0] a, b,
                           input logic [CNTW-1:0] cnt, input logic keep, upper, input int hold);
        exp_t e;
        logic [W-1:0] acc;
        logic c;
        logic [W:0] r;
        logic [W-1:0] held;
        int cyc, nwr, nwru, nex, nmulti;
        acc = ref_acc;
        c = ref_flag;
        if (!keep) acc = upper ? {a[W-1:8], acc[7:0]} : a;
        for (int i = 0; i <= int'(cnt); i++) begin
            r = alu_op(op, acc, b, c);
            {c, acc} = r;
        end
        ref_acc = acc;
        ref_flag = c;
        e.data = acc; e.flag = c;
        e.lat = int'(cnt) + (keep ? 3 : 4);
        e.nex = int'(cnt) + 1;
        e.nwr = (!keep && !upper) ? 1 : 0;
        e.nwru = (!keep && upper) ? 1 : 0;
        sbq.push_back(e);

        drive_req(op, a, b, cnt, keep, upper);
        cyc = 1; nwr = 0; nwru = 0; nex = 0; nmulti = 0;
        while (!rsp_valid && cyc <= 64) begin
            nwr += int'(alu_write);
            nwru += int'(alu_writeu);
            if (!alu_write && !alu_writeu && !alu_read && alu_opcode != '0) nex++;
            if (int'(alu_write) + int'(alu_writeu) + int'(alu_read) > 1) nmulti++;
            @(negedge clk);
            cyc++;
        end
        chk("no_timeout", {31'b0, rsp_valid}, 32'd1);
        e = sbq.pop_front();
        chk("latency", cyc, e.lat);
        chk("exec_cycles", nex, e.nex);
        chk("write_pulses", nwr, e.nwr);
        chk("writeu_pulses", nwru, e.nwru);
        chk("strobe_overlap", nmulti, 0);
        chk("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
        chk("rsp_flag", {31'b0, rsp_flag}, {31'b0, e.flag});
        chk("no_ready_in_resp", {31'b0, req_ready}, 32'd0);
        held = rsp_data;
        for (int i = 0; i < hold; i++) begin
            req_valid = (i == 3);
            req_keep = 1'b0;
            @(negedge clk);
            chk("hold_valid", {31'b0, rsp_valid}, 32'd1);
            chk("hold_data", {16'b0, rsp_data}, {16'b0, held});
            chk("hold_ready", {31'b0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_dropped", {31'b0, rsp_valid}, 32'd0);
        chk("back_idle", {31'b0, req_ready}, 32'd1);
        $display("job op=%0h a=%0h b=%0h cnt=%0d keep=%0d upper=%0d -> data=%0h flag=%0d lat=%0d",
                 op, a, b, cnt, keep, upper, held, rsp_flag, cyc);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, {15'b0, rsp_flag, rsp_data}, 32'd0);
        chk({tag, "_strobes"}, {29'b0, alu_read, alu_write, alu_writeu}, 32'd0);
        chk({tag, "_alu_op"}, {11'b0, alu_opcode, alu_operand}, 32'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        run_job(OP_ADD, 16'h0008, 16'h0002, 4'd0, 1'b0, 1'b0, 0);
        run_job(OP_ADD, 16'h0000, 16'h0005, 4'd1, 1'b1, 1'b0, 0);
        run_job(OP_SHL1, 16'h0001, 16'h0000, 4'd15, 1'b0, 1'b0, 10);
        run_job(OP_ADD, 16'hAB00, 16'h0001, 4'd0, 1'b0, 1'b1, 2);
        run_job(OP_SUB, 16'h0003, 16'h0005, 4'd0, 1'b0, 1'b0, 0);

        // Reset in the middle of EXEC: job must vanish without a response.
        drive_req(OP_ADD, 16'h1111, 16'h0001, 4'd10, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen += int'(rsp_valid);
        end
        chk("midrst_no_rsp", seen, 0);
        $display("reset during EXEC: rsp_valid pulses=%0d", seen);

        run_job(OP_ADD, 16'h1234, 16'h0101, 4'd2, 1'b0, 1'b0, 0);
        run_job(OP_SHR1, 16'h8001, 16'h0000, 4'd0, 1'b0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
